// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined signed Baugh-Wooley multiplier with a per-transaction approximate mode.
// In approximate mode the low APPROX_COLS product columns are OR-compressed and produce no carry.
module approx_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_approx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_y,
    output logic                   out_approx
);

    localparam int PW = 2 * WIDTH;

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("approx_mult_pipe: WIDTH must be within 4..16");
    end
    if (APPROX_COLS < 0 || APPROX_COLS > WIDTH - 1) begin : g_bad_cols
        $error("approx_mult_pipe: APPROX_COLS must be within 0..WIDTH-1");
    end

    logic          s2_adv;
    logic          s1_adv;
    logic          s1_valid;
    logic          s1_approx;
    logic [PW-1:0] s1_sum;
    logic [PW-1:0] s1_carry;
    logic [PW-1:0] s1_low;

    logic [PW-1:0] acc_s;
    logic [PW-1:0] acc_c;
    logic [PW-1:0] nxt_c;
    logic [PW-1:0] pp_row;
    logic [PW-1:0] low_bits;
    logic          pp_bit;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Rows are folded one at a time through a 3:2 compressor; the sum starts
    // from the Baugh-Wooley correction constants at columns WIDTH and 2*WIDTH-1.
    always_comb begin
        acc_s           = '0;
        acc_s[WIDTH]    = 1'b1;
        acc_s[PW-1]     = 1'b1;
        acc_c           = '0;
        nxt_c           = '0;
        pp_row          = '0;
        low_bits        = '0;
        pp_bit          = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pp_row = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp_bit = in_a[i] & in_b[j];
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                    pp_bit = ~pp_bit;
                end
                if (in_approx && ((i + j) < APPROX_COLS)) begin
                    low_bits[i+j] = low_bits[i+j] | pp_bit;
                end else begin
                    pp_row[i+j] = pp_bit;
                end
            end
            nxt_c = ((acc_s & acc_c) | (acc_s & pp_row) | (acc_c & pp_row)) << 1;
            acc_s = acc_s ^ acc_c ^ pp_row;
            acc_c = nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_approx  <= 1'b0;
            s1_sum     <= '0;
            s1_carry   <= '0;
            s1_low     <= '0;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_approx <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sum    <= acc_s;
                    s1_carry  <= acc_c;
                    s1_low    <= low_bits;
                    s1_approx <= in_approx;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    // Masked columns are zero in sum and carry, so adding the OR bits cannot carry.
                    out_y      <= s1_sum + s1_carry + s1_low;
                    out_approx <= s1_approx;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed corners, backpressure, reset flush,
// randomized streaming and parameter variants against a column-count reference model.
module tb_approx_mult_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // main instance: WIDTH=8, K=6
    logic        m_in_valid, m_in_ready, m_in_approx, m_out_valid, m_out_ready, m_out_approx;
    logic [7:0]  m_in_a, m_in_b;
    logic [15:0] m_out_y;
    // K=0 instance
    logic        k_in_valid, k_in_ready, k_in_approx, k_out_valid, k_out_ready, k_out_approx;
    logic [7:0]  k_in_a, k_in_b;
    logic [15:0] k_out_y;
    // WIDTH=4, K=3 instance
    logic        f_in_valid, f_in_ready, f_in_approx, f_out_valid, f_out_ready, f_out_approx;
    logic [3:0]  f_in_a, f_in_b;
    logic [7:0]  f_out_y;
    // WIDTH=16, K=15 instance
    logic        h_in_valid, h_in_ready, h_in_approx, h_out_valid, h_out_ready, h_out_approx;
    logic [15:0] h_in_a, h_in_b;
    logic [31:0] h_out_y;

    approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(6)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_in_a), .in_b(m_in_b), .in_approx(m_in_approx), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out_y(m_out_y), .out_approx(m_out_approx));

    approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(0)) u_k0 (
        .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready),
        .in_a(k_in_a), .in_b(k_in_b), .in_approx(k_in_approx), .out_valid(k_out_valid),
        .out_ready(k_out_ready), .out_y(k_out_y), .out_approx(k_out_approx));

    approx_mult_pipe #(.WIDTH(4), .APPROX_COLS(3)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_a(f_in_a), .in_b(f_in_b), .in_approx(f_in_approx), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_y(f_out_y), .out_approx(f_out_approx));

    approx_mult_pipe #(.WIDTH(16), .APPROX_COLS(15)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_approx(h_in_approx), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out_y(h_out_y), .out_approx(h_out_approx));

    // Reference: exact signed product, then each low column's count replaced by its OR.
    function automatic logic [31:0] ref_y(int w, int k, logic [15:0] a, logic [15:0] b, bit ap);
        longint sa, sb, p, cnt;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        p  = sa * sb;
        if (ap) begin
            for (int col = 0; col < k; col++) begin
                cnt = 0;
                for (int i = 0; i <= col; i++) begin
                    if (a[i] && b[col-i]) cnt++;
                end
                p = p - cnt * (longint'(1) << col) + ((cnt != 0) ? (longint'(1) << col) : 0);
            end
        end
        p = p & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic md,
                            output logic [15:0] y, output logic ap, output bit got);
        int t;
        @(negedge clk);
        m_in_valid = 1'b1; m_in_a = a; m_in_b = b; m_in_approx = md; m_out_ready = 1'b1;
        #1;
        t = 0;
        while (!m_in_ready && t < 10) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        m_in_valid = 1'b0;
        t = 0;
        while (!m_out_valid && t < 10) begin @(negedge clk); t++; end
        got = m_out_valid;
        y   = m_out_y;
        ap  = m_out_approx;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        m_in_valid = 1'b1; m_in_a = 8'd5; m_in_b = 8'd7; m_in_approx = 1'b1; m_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_out_valid !== 1'b0 || m_out_y !== 16'h0000 || m_out_approx !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out_valid=%b out_y=%h out_approx=%b want 0/0000/0",
                     m_out_valid, m_out_y, m_out_approx);
        end
        rst_n = 1'b1;
        m_in_valid = 1'b0;
        #1;
        checks++;
        if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", m_in_ready, m_out_valid);
        end
        // two transactions in flight, then a mid-cycle reset pulse
        @(negedge clk);
        m_out_ready = 1'b0; m_in_valid = 1'b1; m_in_a = 8'd3; m_in_b = 8'd3;
        @(negedge clk);
        m_in_a = 8'd4;
        @(negedge clk);
        m_in_valid = 1'b0;
        #1;
        checks++;
        if (m_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup out_valid=%b want 1", m_out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_immediate out_valid=%b in_ready=%b want 0/1", m_out_valid, m_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; m_out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_result out_valid seen=1 want 0");
        end
    endtask

    task automatic test_exact_corners();
        logic [7:0]  av [4] = '{8'h80, 8'h80, 8'hFF, 8'h00};
        logic [7:0]  bv [4] = '{8'h80, 8'h7F, 8'h01, 8'h5A};
        logic [15:0] ev [4] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
        logic [15:0] y;
        logic        ap;
        bit          got;
        for (int n = 0; n < 4; n++) begin
            send_one(av[n], bv[n], 1'b0, y, ap, got);
            checks++;
            if (!got || y !== ev[n] || ap !== 1'b0) begin
                errors++;
                $display("FAIL exact_%0d got=%0d y=%h ap=%b want y=%h ap=0", n, got, y, ap, ev[n]);
            end
        end
    endtask

    task automatic test_approx_values();
        logic [7:0]  av [4] = '{8'h03, 8'h3F, 8'hFF, 8'h80};
        logic [7:0]  bv [4] = '{8'h03, 8'h3F, 8'h01, 8'h80};
        logic [15:0] ea [4] = '{16'h0007, 16'h0E7F, 16'hFFFF, 16'h4000};
        logic [15:0] ee [4] = '{16'h0009, 16'h0F81, 16'hFFFF, 16'h4000};
        logic [15:0] y;
        logic        ap;
        bit          got;
        for (int n = 0; n < 4; n++) begin
            send_one(av[n], bv[n], 1'b1, y, ap, got);
            checks++;
            if (!got || y !== ea[n] || ap !== 1'b1) begin
                errors++;
                $display("FAIL approx_%0d got=%0d y=%h ap=%b want y=%h ap=1", n, got, y, ap, ea[n]);
            end
            send_one(av[n], bv[n], 1'b0, y, ap, got);
            checks++;
            if (!got || y !== ee[n] || ap !== 1'b0) begin
                errors++;
                $display("FAIL approx_exact_%0d got=%0d y=%h ap=%b want y=%h ap=0", n, got, y, ap, ee[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  ta [3] = '{8'h3F, 8'h3F, 8'h03};
        logic        tm [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] e0, e1, e2;
        logic [15:0] held;
        e0 = ref_y(8, 6, {8'h00, ta[0]}, {8'h00, ta[0]}, tm[0]);
        e1 = ref_y(8, 6, {8'h00, ta[1]}, {8'h00, ta[1]}, tm[1]);
        e2 = ref_y(8, 6, {8'h00, ta[2]}, {8'h00, ta[2]}, tm[2]);
        @(negedge clk);
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_a = ta[0]; m_in_b = ta[0]; m_in_approx = tm[0];
        @(negedge clk);
        m_in_a = ta[1]; m_in_b = ta[1]; m_in_approx = tm[1];
        @(negedge clk);
        m_in_a = ta[2]; m_in_b = ta[2]; m_in_approx = tm[2];
        #1;
        checks++;
        if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full in_ready=%b out_valid=%b want 0/1", m_in_ready, m_out_valid);
        end
        held = m_out_y;
        @(negedge clk);
        #1;
        checks++;
        if (m_out_y !== held || m_out_y !== e0[15:0] || m_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold out_y=%h in_ready=%b want %h/0", m_out_y, m_in_ready, e0[15:0]);
        end
        @(negedge clk);
        m_out_ready = 1'b1;
        #1;
        checks++;
        if (m_out_y !== e0[15:0] || m_out_approx !== tm[0] || m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain0 out_y=%h ap=%b in_ready=%b want %h/%b/1",
                     m_out_y, m_out_approx, m_in_ready, e0[15:0], tm[0]);
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        #1;
        checks++;
        if (m_out_valid !== 1'b1 || m_out_y !== e1[15:0] || m_out_approx !== tm[1]) begin
            errors++;
            $display("FAIL bp_drain1 valid=%b out_y=%h ap=%b want 1/%h/%b",
                     m_out_valid, m_out_y, m_out_approx, e1[15:0], tm[1]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_out_valid !== 1'b1 || m_out_y !== e2[15:0] || m_out_approx !== tm[2]) begin
            errors++;
            $display("FAIL bp_drain2 valid=%b out_y=%h ap=%b want 1/%h/%b",
                     m_out_valid, m_out_y, m_out_approx, e2[15:0], tm[2]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty out_valid=%b want 0", m_out_valid);
        end
    endtask

    task automatic test_stream(input int n, input int p_in, input int p_out, input bit check_lat);
        logic [15:0] qy[$];
        logic        qa[$];
        int          qc[$];
        int          got = 0;
        logic [31:0] e;
        for (int cyc = 0; cyc < n + 4000 && (cyc < n || qy.size() != 0); cyc++) begin
            @(negedge clk);
            m_in_valid  = (cyc < n) && ($urandom_range(99) < p_in);
            m_in_a      = 8'($urandom);
            m_in_b      = 8'($urandom);
            m_in_approx = 1'($urandom);
            m_out_ready = (cyc >= n) || ($urandom_range(99) < p_out);
            #1;
            if (m_out_valid && m_out_ready) begin
                checks++;
                if (qy.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected out_y=%h want no result", m_out_y);
                end else begin
                    if (m_out_y !== qy[0] || m_out_approx !== qa[0] ||
                        (check_lat && (cyc - qc[0]) != 2)) begin
                        errors++;
                        $display("FAIL stream_result out_y=%h ap=%b lat=%0d want %h/%b lat 2",
                                 m_out_y, m_out_approx, cyc - qc[0], qy[0], qa[0]);
                    end
                    void'(qy.pop_front());
                    void'(qa.pop_front());
                    void'(qc.pop_front());
                    got++;
                end
            end
            if (m_in_valid && m_in_ready) begin
                e = ref_y(8, 6, {8'h00, m_in_a}, {8'h00, m_in_b}, m_in_approx);
                qy.push_back(e[15:0]);
                qa.push_back(m_in_approx);
                qc.push_back(cyc);
            end
        end
        m_in_valid = 1'b0;
        checks++;
        if (qy.size() != 0 || (check_lat && got != n)) begin
            errors++;
            $display("FAIL stream_count results=%0d pending=%0d want %0d/0", got, qy.size(), n);
        end
    endtask

    task automatic test_k0();
        logic [15:0] qy[$];
        logic        qa[$];
        int          sent = 0;
        logic [31:0] e;
        for (int it = 0; it < 5000 && (sent < 1000 || qy.size() != 0); it++) begin
            @(negedge clk);
            k_in_valid  = (sent < 1000) && ($urandom_range(99) < 75);
            k_in_a      = 8'($urandom);
            k_in_b      = 8'($urandom);
            k_in_approx = 1'($urandom);
            k_out_ready = $urandom_range(99) < 75;
            #1;
            if (k_out_valid && k_out_ready) begin
                checks++;
                if (qy.size() == 0) begin
                    errors++;
                    $display("FAIL k0_unexpected out_y=%h want no result", k_out_y);
                end else begin
                    if (k_out_y !== qy[0] || k_out_approx !== qa[0]) begin
                        errors++;
                        $display("FAIL k0_result out_y=%h ap=%b want %h/%b", k_out_y, k_out_approx, qy[0], qa[0]);
                    end
                    void'(qy.pop_front());
                    void'(qa.pop_front());
                end
            end
            if (k_in_valid && k_in_ready) begin
                e = ref_y(8, 0, {8'h00, k_in_a}, {8'h00, k_in_b}, 1'b0);
                qy.push_back(e[15:0]);
                qa.push_back(k_in_approx);
                sent++;
            end
        end
        k_in_valid = 1'b0;
        checks++;
        if (sent != 1000 || qy.size() != 0) begin
            errors++;
            $display("FAIL k0_count sent=%0d pending=%0d want 1000/0", sent, qy.size());
        end
    endtask

    task automatic test_w4();
        logic [7:0]  qy[$];
        logic        qa[$];
        int          idx = 0;
        logic [8:0]  iv;
        logic [31:0] e;
        for (int it = 0; it < 5000 && (idx < 512 || qy.size() != 0); it++) begin
            @(negedge clk);
            iv          = 9'(idx);
            f_in_valid  = (idx < 512) && ($urandom_range(99) < 70);
            f_in_a      = iv[3:0];
            f_in_b      = iv[7:4];
            f_in_approx = iv[8];
            f_out_ready = $urandom_range(99) < 70;
            #1;
            if (f_out_valid && f_out_ready) begin
                checks++;
                if (qy.size() == 0) begin
                    errors++;
                    $display("FAIL w4_unexpected out_y=%h want no result", f_out_y);
                end else begin
                    if (f_out_y !== qy[0] || f_out_approx !== qa[0]) begin
                        errors++;
                        $display("FAIL w4_result out_y=%h ap=%b want %h/%b", f_out_y, f_out_approx, qy[0], qa[0]);
                    end
                    void'(qy.pop_front());
                    void'(qa.pop_front());
                end
            end
            if (f_in_valid && f_in_ready) begin
                e = ref_y(4, 3, {12'h000, f_in_a}, {12'h000, f_in_b}, f_in_approx);
                qy.push_back(e[7:0]);
                qa.push_back(f_in_approx);
                idx++;
            end
        end
        f_in_valid = 1'b0;
        checks++;
        if (idx != 512 || qy.size() != 0) begin
            errors++;
            $display("FAIL w4_count sent=%0d pending=%0d want 512/0", idx, qy.size());
        end
    endtask

    task automatic test_w16();
        logic [31:0] qy[$];
        logic        qa[$];
        int          sent = 0;
        for (int it = 0; it < 30000 && (sent < 10000 || qy.size() != 0); it++) begin
            @(negedge clk);
            h_in_valid  = (sent < 10000) && ($urandom_range(99) < 90);
            h_in_a      = 16'($urandom);
            h_in_b      = 16'($urandom);
            h_in_approx = 1'($urandom);
            h_out_ready = $urandom_range(99) < 90;
            #1;
            if (h_out_valid && h_out_ready) begin
                checks++;
                if (qy.size() == 0) begin
                    errors++;
                    $display("FAIL w16_unexpected out_y=%h want no result", h_out_y);
                end else begin
                    if (h_out_y !== qy[0] || h_out_approx !== qa[0]) begin
                        errors++;
                        $display("FAIL w16_result out_y=%h ap=%b want %h/%b", h_out_y, h_out_approx, qy[0], qa[0]);
                    end
                    void'(qy.pop_front());
                    void'(qa.pop_front());
                end
            end
            if (h_in_valid && h_in_ready) begin
                qy.push_back(ref_y(16, 15, h_in_a, h_in_b, h_in_approx));
                qa.push_back(h_in_approx);
                sent++;
            end
        end
        h_in_valid = 1'b0;
        checks++;
        if (sent != 10000 || qy.size() != 0) begin
            errors++;
            $display("FAIL w16_count sent=%0d pending=%0d want 10000/0", sent, qy.size());
        end
    endtask

    initial begin
        m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_approx = 1'b0; m_out_ready = 1'b1;
        k_in_valid = 1'b0; k_in_a = '0; k_in_b = '0; k_in_approx = 1'b0; k_out_ready = 1'b1;
        f_in_valid = 1'b0; f_in_a = '0; f_in_b = '0; f_in_approx = 1'b0; f_out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_approx = 1'b0; h_out_ready = 1'b1;
        test_reset();
        test_exact_corners();
        test_approx_values();
        test_backpressure();
        test_stream(1000, 100, 100, 1'b1);
        test_stream(1000, 60, 60, 1'b0);
        test_k0();
        test_w4();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
